// File: rtl/pipe_pkg.sv
// Shared types and constants for the five-stage pipeline register slice.
package pipe_pkg;

    // Decoded control bits that travel with an instruction from D onwards.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic reg_dst;
    } ctrl_t;

    // Forwarding operand selects; 2'b11 is reserved and behaves like FWD_RF.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    // D/E register contents.
    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } de_t;

    // E/M register contents.
    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  dst;
        logic [31:0] alu_out;
    } em_t;

    // M/W register contents.
    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [4:0]  dst;
        logic [31:0] alu_out;
        logic [31:0] read_data;
    } mw_t;

    // Operand forwarding mux shared by both ALU inputs.
    function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                            input logic [31:0] rf_val,
                                            input logic [31:0] w_val,
                                            input logic [31:0] m_val);
        logic [31:0] val;
        case (sel)
            FWD_W:   val = w_val;
            FWD_M:   val = m_val;
            default: val = rf_val;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/pipeline_regs_pipe_reg.sv
// Generic stage register: synchronous reset, synchronous clear, load enable.
// Priority is reset, then clear, then enable; clear wins over a deasserted enable.
module pipe_reg #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] data_d;
    logic [Width-1:0] data_q;

    // Next-state selection: bubble on clear, load on enable, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (clr_i) begin
            data_d = '0;
        end else if (en_i) begin
            data_d = d_i;
        end
    end

    // State update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipeline_regs.sv
// Pipeline register slice of a classic five-stage MIPS-style core: PC, F/D, D/E,
// E/M and M/W registers, E-stage operand forwarding and a PC-stall counter.
module pipeline_regs
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next_F,
    output logic [31:0] pc_F,
    input  logic        pc_enab,
    input  logic [31:0] instr_F,
    input  logic        enab_FD,
    output logic [31:0] instr_D,
    output logic [4:0]  rs_D,
    output logic [4:0]  rt_D,
    input  logic        reg_write_D,
    input  logic        mem_to_reg_D,
    input  logic        reg_dst_D,
    input  logic [31:0] rd1_D,
    input  logic [31:0] rd2_D,
    input  logic        flush_DE,
    output logic [4:0]  rs_E,
    output logic [4:0]  rt_E,
    output logic [4:0]  rd_E,
    output logic        mem_to_reg_E,
    input  logic [1:0]  forwardA_E,
    input  logic [1:0]  forwardB_E,
    output logic [31:0] src_a_E,
    output logic [31:0] src_b_E,
    input  logic [31:0] alu_result_E,
    output logic [31:0] alu_out_M,
    output logic [4:0]  reg_id_M,
    output logic        reg_write_M,
    input  logic [31:0] read_data_M,
    output logic [31:0] result_W,
    output logic [4:0]  reg_id_W,
    output logic        reg_write_W,
    output logic [15:0] stall_count
);

    de_t         de_d, de_q;
    em_t         em_d, em_q;
    mw_t         mw_d, mw_q;
    logic [4:0]  dst_E;
    logic [15:0] stall_d, stall_q;
    logic        stall_en;

    // ---------------- Fetch: PC ----------------
    pipe_reg #(.Width(32)) u_pc (
        .clk   (clk),
        .reset (reset),
        .en_i  (pc_enab),
        .clr_i (1'b0),
        .d_i   (pc_next_F),
        .q_o   (pc_F)
    );

    // ---------------- F/D ----------------
    pipe_reg #(.Width(32)) u_fd (
        .clk   (clk),
        .reset (reset),
        .en_i  (enab_FD),
        .clr_i (1'b0),
        .d_i   (instr_F),
        .q_o   (instr_D)
    );

    assign rs_D = instr_D[25:21];
    assign rt_D = instr_D[20:16];

    // D/E payload assembled from decode controls, register reads and instruction fields.
    always_comb begin
        de_d                 = '0;
        de_d.ctrl.reg_write  = reg_write_D;
        de_d.ctrl.mem_to_reg = mem_to_reg_D;
        de_d.ctrl.reg_dst    = reg_dst_D;
        de_d.rd1             = rd1_D;
        de_d.rd2             = rd2_D;
        de_d.rs              = instr_D[25:21];
        de_d.rt              = instr_D[20:16];
        de_d.rd              = instr_D[15:11];
    end

    // ---------------- D/E: loads every cycle, flush inserts a bubble ----------------
    pipe_reg #(.Width($bits(de_t))) u_de (
        .clk   (clk),
        .reset (reset),
        .en_i  (1'b1),
        .clr_i (flush_DE),
        .d_i   (de_d),
        .q_o   (de_q)
    );

    assign rs_E         = de_q.rs;
    assign rt_E         = de_q.rt;
    assign rd_E         = de_q.rd;
    assign mem_to_reg_E = de_q.ctrl.mem_to_reg;
    assign dst_E        = de_q.ctrl.reg_dst ? de_q.rd : de_q.rt;

    // Forwarded ALU operands; result_W and alu_out_M are the bypass sources.
    always_comb begin
        src_a_E = fwd_mux(forwardA_E, de_q.rd1, result_W, em_q.alu_out);
        src_b_E = fwd_mux(forwardB_E, de_q.rd2, result_W, em_q.alu_out);
    end

    // E/M payload.
    always_comb begin
        em_d            = '0;
        em_d.reg_write  = de_q.ctrl.reg_write;
        em_d.mem_to_reg = de_q.ctrl.mem_to_reg;
        em_d.dst        = dst_E;
        em_d.alu_out    = alu_result_E;
    end

    // ---------------- E/M: no enable, so E-to-W latency never stretches ----------------
    pipe_reg #(.Width($bits(em_t))) u_em (
        .clk   (clk),
        .reset (reset),
        .en_i  (1'b1),
        .clr_i (1'b0),
        .d_i   (em_d),
        .q_o   (em_q)
    );

    assign alu_out_M   = em_q.alu_out;
    assign reg_id_M    = em_q.dst;
    assign reg_write_M = em_q.reg_write;

    // M/W payload.
    always_comb begin
        mw_d            = '0;
        mw_d.reg_write  = em_q.reg_write;
        mw_d.mem_to_reg = em_q.mem_to_reg;
        mw_d.dst        = em_q.dst;
        mw_d.alu_out    = em_q.alu_out;
        mw_d.read_data  = read_data_M;
    end

    // ---------------- M/W ----------------
    pipe_reg #(.Width($bits(mw_t))) u_mw (
        .clk   (clk),
        .reset (reset),
        .en_i  (1'b1),
        .clr_i (1'b0),
        .d_i   (mw_d),
        .q_o   (mw_q)
    );

    assign result_W    = mw_q.mem_to_reg ? mw_q.read_data : mw_q.alu_out;
    assign reg_id_W    = mw_q.dst;
    assign reg_write_W = mw_q.reg_write;

    // Saturating stall counter: advance on PC-stall cycles until all ones.
    always_comb begin
        stall_en = !pc_enab && (stall_q != STALL_MAX);
        stall_d  = stall_q + 16'd1;
    end

    pipe_reg #(.Width(16)) u_stall (
        .clk   (clk),
        .reset (reset),
        .en_i  (stall_en),
        .clr_i (1'b0),
        .d_i   (stall_d),
        .q_o   (stall_q)
    );

    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_regs.sv
// Directed self-checking bench for pipeline_regs.
module tb_pipeline_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_next_F;
    logic [31:0] pc_F;
    logic        pc_enab;
    logic [31:0] instr_F;
    logic        enab_FD;
    logic [31:0] instr_D;
    logic [4:0]  rs_D, rt_D;
    logic        reg_write_D, mem_to_reg_D, reg_dst_D;
    logic [31:0] rd1_D, rd2_D;
    logic        flush_DE;
    logic [4:0]  rs_E, rt_E, rd_E;
    logic        mem_to_reg_E;
    logic [1:0]  forwardA_E, forwardB_E;
    logic [31:0] src_a_E, src_b_E;
    logic [31:0] alu_result_E;
    logic [31:0] alu_out_M;
    logic [4:0]  reg_id_M;
    logic        reg_write_M;
    logic [31:0] read_data_M;
    logic [31:0] result_W;
    logic [4:0]  reg_id_W;
    logic        reg_write_W;
    logic [15:0] stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_regs dut (
        .clk          (clk),
        .reset        (reset),
        .pc_next_F    (pc_next_F),
        .pc_F         (pc_F),
        .pc_enab      (pc_enab),
        .instr_F      (instr_F),
        .enab_FD      (enab_FD),
        .instr_D      (instr_D),
        .rs_D         (rs_D),
        .rt_D         (rt_D),
        .reg_write_D  (reg_write_D),
        .mem_to_reg_D (mem_to_reg_D),
        .reg_dst_D    (reg_dst_D),
        .rd1_D        (rd1_D),
        .rd2_D        (rd2_D),
        .flush_DE     (flush_DE),
        .rs_E         (rs_E),
        .rt_E         (rt_E),
        .rd_E         (rd_E),
        .mem_to_reg_E (mem_to_reg_E),
        .forwardA_E   (forwardA_E),
        .forwardB_E   (forwardB_E),
        .src_a_E      (src_a_E),
        .src_b_E      (src_b_E),
        .alu_result_E (alu_result_E),
        .alu_out_M    (alu_out_M),
        .reg_id_M     (reg_id_M),
        .reg_write_M  (reg_write_M),
        .read_data_M  (read_data_M),
        .result_W     (result_W),
        .reg_id_W     (reg_id_W),
        .reg_write_W  (reg_write_W),
        .stall_count  (stall_count)
    );

    // One rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pc_next_F = 32'h0; pc_enab = 1'b0; instr_F = 32'h0; enab_FD = 1'b0;
        reg_write_D = 1'b0; mem_to_reg_D = 1'b0; reg_dst_D = 1'b0; rd1_D = 32'h0;
        rd2_D = 32'h0; flush_DE = 1'b0; forwardA_E = 2'b00; forwardB_E = 2'b00;
        alu_result_E = 32'h0; read_data_M = 32'h0;
        step();
        step();
        reset = 1'b0;
        total++; if (pc_F !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc_F); end
        total++; if (instr_D !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr_D); end
        total++; if (stall_count !== 16'h0) begin bad++; $display("FAIL rst_stall got=%h exp=0", stall_count); end
        total++; if (reg_write_M !== 1'b0 || reg_write_W !== 1'b0) begin
            bad++; $display("FAIL rst_rw got=%b%b exp=00", reg_write_M, reg_write_W);
        end
        total++; if (result_W !== 32'h0) begin bad++; $display("FAIL rst_result got=%h exp=0", result_W); end
    endtask

    task automatic test_pc_load();
        pc_next_F = 32'h4; pc_enab = 1'b1; enab_FD = 1'b1; instr_F = 32'h8C0A0004;
        step();
        total++; if (pc_F !== 32'h4) begin bad++; $display("FAIL pc_load got=%h exp=4", pc_F); end
        total++; if (stall_count !== 16'h0) begin bad++; $display("FAIL pc_stall0 got=%h exp=0", stall_count); end
        total++; if (instr_D !== 32'h8C0A0004) begin bad++; $display("FAIL fd_load got=%h exp=8c0a0004", instr_D); end
        total++; if (rs_D !== 5'd0 || rt_D !== 5'd10) begin
            bad++; $display("FAIL rs_rt_D got=%0d,%0d exp=0,10", rs_D, rt_D);
        end
    endtask

    task automatic test_stall();
        pc_next_F = 32'h8; pc_enab = 1'b0; enab_FD = 1'b0; flush_DE = 1'b1; instr_F = 32'hFFFFFFFF;
        reg_write_D = 1'b1; mem_to_reg_D = 1'b1; rd1_D = 32'h1; rd2_D = 32'h2;
        step();
        total++; if (instr_D !== 32'h8C0A0004) begin bad++; $display("FAIL stall_fd got=%h exp=8c0a0004", instr_D); end
        total++; if (pc_F !== 32'h4) begin bad++; $display("FAIL stall_pc got=%h exp=4", pc_F); end
        total++; if (mem_to_reg_E !== 1'b0) begin bad++; $display("FAIL bubble_mtr got=%b exp=0", mem_to_reg_E); end
        total++; if (rs_E !== 5'd0 || rt_E !== 5'd0 || rd_E !== 5'd0) begin
            bad++; $display("FAIL bubble_ids got=%0d,%0d,%0d exp=0,0,0", rs_E, rt_E, rd_E);
        end
        total++; if (stall_count !== 16'h1) begin bad++; $display("FAIL stall_cnt got=%h exp=1", stall_count); end
    endtask

    task automatic test_load_to_wb();
        // Release the stall: the held lw enters E; the bubble advances into M.
        flush_DE = 1'b0; pc_enab = 1'b1; enab_FD = 1'b1; instr_F = 32'h00000000;
        reg_write_D = 1'b1; mem_to_reg_D = 1'b1; reg_dst_D = 1'b0;
        step();
        total++; if (reg_write_M !== 1'b0) begin bad++; $display("FAIL bubble_rw got=%b exp=0", reg_write_M); end
        total++; if (rt_E !== 5'd10 || rs_E !== 5'd0 || mem_to_reg_E !== 1'b1) begin
            bad++; $display("FAIL lw_in_E got=rt%0d rs%0d m%b exp=rt10 rs0 m1", rt_E, rs_E, mem_to_reg_E);
        end
        reg_write_D = 1'b0; mem_to_reg_D = 1'b0; alu_result_E = 32'h100;
        step();
        total++; if (reg_id_M !== 5'd10 || reg_write_M !== 1'b1 || alu_out_M !== 32'h100) begin
            bad++; $display("FAIL lw_in_M got=id%0d rw%b a%h exp=id10 rw1 a100", reg_id_M, reg_write_M, alu_out_M);
        end
        read_data_M = 32'h55;
        step();
        total++; if (reg_id_W !== 5'd10 || reg_write_W !== 1'b1 || result_W !== 32'h55) begin
            bad++; $display("FAIL lw_in_W got=id%0d rw%b r%h exp=id10 rw1 r55", reg_id_W, reg_write_W, result_W);
        end
    endtask

    task automatic test_forward();
        // add $11,$9,$10 with reg_dst=1; alu values BEEF then DEAD fill W and M.
        instr_F = 32'h012A5820; reg_write_D = 1'b1; mem_to_reg_D = 1'b0; reg_dst_D = 1'b1;
        rd1_D = 32'h1; rd2_D = 32'h2; alu_result_E = 32'hBEEF; read_data_M = 32'h0;
        step();
        alu_result_E = 32'hDEAD;
        step();
        total++; if (alu_out_M !== 32'hDEAD || result_W !== 32'hBEEF) begin
            bad++; $display("FAIL fwd_setup got=M%h W%h exp=Mdead Wbeef", alu_out_M, result_W);
        end
        total++; if (rs_E !== 5'd9 || rt_E !== 5'd10 || rd_E !== 5'd11) begin
            bad++; $display("FAIL add_ids got=%0d,%0d,%0d exp=9,10,11", rs_E, rt_E, rd_E);
        end
        forwardA_E = 2'b10; forwardB_E = 2'b01; #1;
        total++; if (src_a_E !== 32'hDEAD) begin bad++; $display("FAIL fwdA_M got=%h exp=dead", src_a_E); end
        total++; if (src_b_E !== 32'hBEEF) begin bad++; $display("FAIL fwdB_W got=%h exp=beef", src_b_E); end
        forwardA_E = 2'b00; forwardB_E = 2'b00; #1;
        total++; if (src_a_E !== 32'h1 || src_b_E !== 32'h2) begin
            bad++; $display("FAIL fwd_rf got=%h,%h exp=1,2", src_a_E, src_b_E);
        end
        forwardA_E = 2'b11; forwardB_E = 2'b11; #1;
        total++; if (src_a_E !== 32'h1 || src_b_E !== 32'h2) begin
            bad++; $display("FAIL fwd_rsvd got=%h,%h exp=1,2", src_a_E, src_b_E);
        end
        forwardA_E = 2'b01; forwardB_E = 2'b10; #1;
        total++; if (src_a_E !== 32'hBEEF || src_b_E !== 32'hDEAD) begin
            bad++; $display("FAIL fwd_swap got=%h,%h exp=beef,dead", src_a_E, src_b_E);
        end
        forwardA_E = 2'b00; forwardB_E = 2'b00; alu_result_E = 32'h0;
        step();
        total++; if (reg_id_M !== 5'd11) begin bad++; $display("FAIL reg_dst_rd got=%0d exp=11", reg_id_M); end
    endtask

    task automatic test_reset_mid();
        total++; if (reg_write_M !== 1'b1 || reg_write_W !== 1'b1) begin
            bad++; $display("FAIL pre_rst_rw got=%b%b exp=11", reg_write_M, reg_write_W);
        end
        total++; if (stall_count !== 16'h1) begin bad++; $display("FAIL pre_rst_stall got=%h exp=1", stall_count); end
        // Enables stay asserted so reset priority is exercised.
        reset = 1'b1; pc_enab = 1'b1; enab_FD = 1'b1; pc_next_F = 32'h40; flush_DE = 1'b0;
        step();
        reset = 1'b0; pc_enab = 1'b0; reg_write_D = 1'b0; enab_FD = 1'b0;
        total++; if (reg_write_M !== 1'b0 || reg_write_W !== 1'b0) begin
            bad++; $display("FAIL mid_rst_rw got=%b%b exp=00", reg_write_M, reg_write_W);
        end
        total++; if (stall_count !== 16'h0) begin bad++; $display("FAIL mid_rst_stall got=%h exp=0", stall_count); end
        total++; if (pc_F !== 32'h0 || instr_D !== 32'h0 || rd_E !== 5'd0) begin
            bad++; $display("FAIL mid_rst_regs got=pc%h i%h rd%0d exp=0", pc_F, instr_D, rd_E);
        end
    endtask

    task automatic test_saturate();
        // pc_enab is already 0 from the previous task.
        repeat (65534) @(posedge clk);
        #1;
        total++; if (stall_count !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", stall_count); end
        step();
        total++; if (stall_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hit got=%h exp=ffff", stall_count); end
        repeat (70000 - 65535) @(posedge clk);
        #1;
        total++; if (stall_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", stall_count); end
        total++; if (pc_F !== 32'h0) begin bad++; $display("FAIL sat_pc got=%h exp=0", pc_F); end
    endtask

    initial begin
        test_reset();
        test_pc_load();
        test_stall();
        test_load_to_wb();
        test_forward();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_regs.md
PIPELINE_REGS -- requirements
Module: pipeline_regs

Interface
REQ-001 SHALL provide: clk  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL provide: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL provide: pc_next_F  in  32  next PC; pc_F  out  32  current fetch PC.
REQ-004 SHALL provide: pc_enab  in  1  PC load enable, from hazard logic.
REQ-005 SHALL provide: instr_F  in  32  fetched instruction.
REQ-006 SHALL provide: enab_FD  in  1  F/D register load enable.
REQ-007 SHALL provide: instr_D  out  32  decode-stage instruction.
REQ-008 SHALL provide: rs_D, rt_D  out  5 each  instr_D[25:21], instr_D[20:16].
REQ-009 SHALL provide: reg_write_D, mem_to_reg_D, reg_dst_D  in  1 each  decoded controls.
REQ-010 SHALL provide: rd1_D, rd2_D  in  32 each  register-file read data.
REQ-011 SHALL provide: flush_DE  in  1  D/E bubble insert.
REQ-012 SHALL provide: rs_E, rt_E, rd_E  out  5 each  E-stage register ids.
REQ-013 SHALL provide: mem_to_reg_E  out  1  E-stage load flag.
REQ-014 SHALL provide: forwardA_E, forwardB_E  in  2 each  operand select.
REQ-015 SHALL provide: src_a_E, src_b_E  out  32 each  forwarded ALU operands.
REQ-016 SHALL provide: alu_result_E  in  32  ALU output.
REQ-017 SHALL provide: alu_out_M  out  32; reg_id_M  out  5; reg_write_M  out  1.
REQ-018 SHALL provide: read_data_M  in  32  data-memory read data.
REQ-019 SHALL provide: result_W  out  32; reg_id_W  out  5; reg_write_W  out  1.
REQ-020 SHALL provide: stall_count  out  16  saturating count of PC-stall cycles.

Function
REQ-021 SHALL load pc_F from pc_next_F when pc_enab=1 and hold pc_F otherwise.
REQ-022 SHALL load instr_D from instr_F when enab_FD=1 and hold instr_D otherwise.
REQ-023 SHALL load the D/E register every cycle: controls, rd1/rd2, rs/rt/rd from instr_D[25:11].
REQ-024 SHALL, when flush_DE=1, load all D/E fields as 0 (bubble: reg_write_E=0, mem_to_reg_E=0, ids 0).
REQ-025 SHALL treat flush_DE and enab_FD=0 together as a stall: F/D holds and D/E receives a bubble in the same edge.
REQ-026 SHALL compute the E destination combinationally: reg_dst_E ? rd_E : rt_E.
REQ-027 SHALL load E/M (alu_out, destination, reg_write, mem_to_reg) and M/W (alu_out, read_data, destination, reg_write, mem_to_reg) every cycle, with no enable.
REQ-028 SHALL select src_a_E by forwardA_E: 00 = rd1_E, 01 = result_W, 10 = alu_out_M, 11 = rd1_E (reserved).
REQ-029 SHALL select src_b_E by forwardB_E in the same way, with rd2_E in place of rd1_E.
REQ-030 SHALL compute result_W = mem_to_reg_W ? read_data_W : alu_out_W combinationally.
REQ-031 SHALL increment stall_count on each edge where pc_enab=0, and hold it at 16'hFFFF once reached.
REQ-032 SHALL give the E-to-W latency of an instruction as exactly 2 edges, independent of stalls.

Reset
REQ-033 SHALL zero every register on a reset edge, including pc_F, instr_D, all pipeline fields and stall_count.
REQ-034 SHALL give reset priority over pc_enab, enab_FD and flush_DE.
REQ-035 SHALL, on reset asserted mid-stream, zero reg_write_M and reg_write_W after one edge, so no stale writes remain.

Structure
REQ-036 SHALL place ctrl_t (reg_write, mem_to_reg, reg_dst) and the FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10 constants in shared package pipe_pkg.
REQ-037 SHALL implement every stage register with one parameterized sub-module, pipe_reg (width, enable, synchronous clear).

Verification
REQ-038 SHALL check: reset, then pc_next_F=32'h4 with pc_enab=1 for 1 edge -> pc_F=32'h4 and stall_count=0.
REQ-039 SHALL check: pc_enab=0, enab_FD=0, flush_DE=1 for 1 edge with instr_D=32'h8C0A0004 -> instr_D unchanged, reg_write_E=0, mem_to_reg_E=0, stall_count=1.
REQ-040 SHALL check: forwardA_E=10, alu_out_M=32'hDEAD, rd1_E=32'h1 -> src_a_E=32'hDEAD; forwardB_E=01, result_W=32'hBEEF -> src_b_E=32'hBEEF.
REQ-041 SHALL check: load in E with reg_dst_D=0, rt=5'd10, read_data_M=32'h55 -> after 2 edges reg_id_W=10, reg_write_W=1, result_W=32'h55.
REQ-042 SHALL check: pc_enab=0 held for 70000 cycles -> stall_count=16'hFFFF and holds.
REQ-043 SHALL check: reset asserted while reg_write_M=reg_write_W=1 -> both 0 and stall_count=0 after one edge.
